pmod_btn_debounce: RTL

PMOD_BTN_DEBOUNCE -- requirements
Module: pmod_btn_debounce

---
 rtl/pmod_btn_debounce.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pmod_btn_debounce.sv
// Multi-button debouncer for PMod pads: per-button synchronizer, stability counter,
// and press/release/auto-repeat event generation.
module pmod_btn_debounce #(
  parameter int NBTNS    = 4,
  parameter int CTRBITS  = 18,
  parameter int DEBOUNCE = 250000,
  parameter int HOLD     = 0,
  parameter int REPEAT   = 0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NBTNS-1:0] i_btn,
  output logic [NBTNS-1:0] o_btn,
  output logic [NBTNS-1:0] o_press,
  output logic [NBTNS-1:0] o_release,
  output logic             o_any
);

  localparam logic [CTRBITS-1:0] DB_LAST   = CTRBITS'(DEBOUNCE - 1);
  localparam logic [CTRBITS-1:0] HOLD_LAST = CTRBITS'((HOLD > 0) ? HOLD - 1 : 0);
  localparam logic [CTRBITS-1:0] REP_LAST  = CTRBITS'((REPEAT > 0) ? REPEAT - 1 : 0);
  localparam bit                 RPT_EN    = (HOLD != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_RPT} state_t;

  logic [NBTNS-1:0] w_press_nxt;
  logic [NBTNS-1:0] w_release_nxt;

  generate
    for (genvar gi = 0; gi < NBTNS; gi++) begin : g_btn
      logic [1:0]         r_sync;
      logic               r_btn;
      logic [CTRBITS-1:0] r_dc;
      logic [CTRBITS-1:0] r_rc;
      state_t             r_state;
      logic               w_s;
      logic               w_accept;
      logic               w_expire;

      assign w_s      = r_sync[1];
      assign w_accept = (w_s != r_btn) && (r_dc == DB_LAST);
      assign w_expire = RPT_EN &&
                        (((r_state == ST_HELD) && (r_rc == HOLD_LAST)) ||
                         ((r_state == ST_RPT)  && (r_rc == REP_LAST)));

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_sync <= 2'b00;
        end else begin
          r_sync <= {r_sync[0], i_btn[gi]};
        end
      end

      // Any sample agreeing with the accepted level restarts the stability count.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_dc  <= '0;
          r_btn <= 1'b0;
        end else if (w_s == r_btn) begin
          r_dc <= '0;
        end else if (r_dc == DB_LAST) begin
          r_btn <= w_s;
          r_dc  <= '0;
        end else begin
          r_dc <= r_dc + CTRBITS'(1);
        end
      end

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_state <= ST_IDLE;
          r_rc    <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_accept && w_s) begin
                r_state <= ST_HELD;
                r_rc    <= '0;
              end
            end
            ST_HELD, ST_RPT: begin
              if (w_accept && !w_s) begin
                r_state <= ST_IDLE;
                r_rc    <= '0;
              end else if (RPT_EN) begin
                if (w_expire) begin
                  r_state <= ST_RPT;
                  r_rc    <= '0;
                end else begin
                  r_rc <= r_rc + CTRBITS'(1);
                end
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_rc    <= '0;
            end
          endcase
        end
      end

      // In HELD/RPT an accept can only be a release, which suppresses a coincident repeat.
      assign w_press_nxt[gi]   = (w_accept && w_s) || (w_expire && !w_accept);
      assign w_release_nxt[gi] = w_accept && !w_s;
      assign o_btn[gi]         = r_btn;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_press   <= '0;
      o_release <= '0;
      o_any     <= 1'b0;
    end else begin
      o_press   <= w_press_nxt;
      o_release <= w_release_nxt;
      o_any     <= |w_press_nxt;
    end
  end

endmodule
